// File: rtl/dot11_tx_scheduler.sv
// Round-robin frame scheduler for four TX queues sharing one frame BRAM: start pulse,
// started/done watchdogs, transmitter abort via phy_tx_arest, and an inter-frame gap.
module dot11_tx_scheduler #(
  parameter int unsigned IFS_CYCLES    = 16,
  parameter int unsigned START_TIMEOUT = 256,
  parameter int unsigned DONE_TIMEOUT  = 4000000,
  parameter int unsigned ABORT_CYCLES  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  q_req,
  output logic [3:0]  q_ack,
  output logic [3:0]  q_err,
  output logic        phy_tx_start,
  input  logic        phy_tx_started,
  input  logic        phy_tx_done,
  output logic        phy_tx_arest,
  input  logic [11:0] phy_bram_addr,
  output logic [11:0] mem_addr,
  output logic [1:0]  cur_queue,
  output logic        busy
);

  if (START_TIMEOUT >= 32'd16777216 || DONE_TIMEOUT >= 32'd16777216 ||
      IFS_CYCLES >= 32'd16777216 || ABORT_CYCLES < 32'd1) begin : g_bad_params
    $error("dot11_tx_scheduler: timeouts must be below 2^24 and ABORT_CYCLES at least 1");
  end

  localparam logic [23:0] START_LIM  = 24'(START_TIMEOUT);
  localparam logic [23:0] DONE_LIM   = 24'(DONE_TIMEOUT);
  localparam logic [23:0] IFS_LIM    = 24'(IFS_CYCLES);
  localparam logic [23:0] ABORT_LAST = 24'(ABORT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_STARTED, WAIT_DONE, ABORT, IFS} state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  cur_q, cur_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  ack_q, ack_d;
  logic [3:0]  err_q, err_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        arest_q, arest_d;

  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;
  logic        unused_addr_bits;

  // Descending scan so the candidate nearest after last_grant is assigned last and wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_q;
    cand      = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (q_req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 24'd1;
    cur_d   = cur_q;
    last_d  = last_q;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_vld) begin
          state_d = START;
          cur_d   = grant_idx;
          last_d  = grant_idx;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_STARTED;
      end
      WAIT_STARTED: begin
        if (phy_tx_done) begin
          ack_d[cur_q] = 1'b1;
          state_d      = IFS;
          cnt_d        = '0;
        end else if (phy_tx_started) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == START_LIM) begin
          err_d[cur_q] = 1'b1;
          state_d      = ABORT;
          cnt_d        = '0;
        end
      end
      WAIT_DONE: begin
        // done is checked first so a completion on the expiry cycle is still acked
        if (phy_tx_done) begin
          ack_d[cur_q] = 1'b1;
          state_d      = IFS;
          cnt_d        = '0;
        end else if (cnt_q == DONE_LIM) begin
          err_d[cur_q] = 1'b1;
          state_d      = ABORT;
          cnt_d        = '0;
        end
      end
      ABORT: begin
        if (cnt_q == ABORT_LAST) begin
          state_d = IFS;
          cnt_d   = '0;
        end
      end
      IFS: begin
        if (cnt_q == IFS_LIM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign start_d = (state_q == START);
  assign busy_d  = (state_d != IDLE);
  assign arest_d = (state_d == ABORT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= 2'd0;
      last_q  <= 2'd3;
      ack_q   <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      arest_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      arest_q <= arest_d;
    end
  end

  assign q_ack            = ack_q;
  assign q_err            = err_q;
  assign phy_tx_start     = start_q;
  assign phy_tx_arest     = arest_q;
  assign cur_queue        = cur_q;
  assign busy             = busy_q;
  assign mem_addr         = {cur_q, phy_bram_addr[9:0]};
  assign unused_addr_bits = ^phy_bram_addr[11:10];

endmodule
